sprite_scheduler: RTL and testbench

Per-pixel sprite and background sequencer for the ROJO Bot display pipeline, sitting between the dtg/world-map lookup and the colorizer. It latches hero and monster world positions once per frame and computes screen-relative, clipped sprite coordinates. It drives addresses to the hero, monster and background block ROMs and realigns their 1-cycle read data. It then arbitrates layer priority (hero > monster > background) into a single 12-bit pixel with a fixed 3-cycle latency.

---
 rtl/sprite_scheduler_pkg.sv | 66 ++++++
 rtl/sprite_window.sv | 29 ++
 rtl/sprite_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_sprite_scheduler.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_scheduler_pkg.sv
// Shared constants, codes and pipeline types for the ROJO Bot sprite scheduler.
// Imported by the window helper and the scheduler top.
package sprite_scheduler_pkg;

    localparam logic [11:0] TRANSPARENT = 12'h000;
    localparam int          SPR_SIZE    = 128;
    localparam int          HERO_COL0   = 448;
    localparam int          HERO_ROW0   = 320;

    localparam int SCREEN_W = 1024;
    localparam int SCREEN_H = 768;

    localparam logic [0:0] WAIT_FRAME = 1'b0;
    localparam logic [0:0] ACTIVE     = 1'b1;

    typedef enum logic [2:0] {
        BACK  = 3'b000,
        RIGHT = 3'b010,
        FRONT = 3'b100,
        LEFT  = 3'b110
    } orient_e;

    typedef enum logic [1:0] {
        DIRT     = 2'd0,
        DIRT_ALT = 2'd1,
        WALL     = 2'd2,
        GRASS    = 2'd3
    } world_e;

    typedef enum logic [1:0] {
        VIEW_FRONT,
        VIEW_BACK,
        VIEW_LEFT,
        VIEW_RIGHT
    } hero_view_e;

    typedef struct packed {
        logic       valid;
        hero_view_e view;
    } hero_sel_t;

    // Side-band travelling alongside the ROM read so it lines up with the data.
    typedef struct packed {
        logic      run;
        logic      video_on;
        world_e    world;
        logic      hero_hit;
        logic      mon_hit;
        hero_sel_t orient;
    } side_t;

    function automatic hero_sel_t decode_orient(input logic [2:0] code);
        hero_sel_t sel;
        sel.valid = 1'b1;
        sel.view  = VIEW_FRONT;
        case (code)
            FRONT:   sel.view  = VIEW_FRONT;
            BACK:    sel.view  = VIEW_BACK;
            LEFT:    sel.view  = VIEW_LEFT;
            RIGHT:   sel.view  = VIEW_RIGHT;
            default: sel.valid = 1'b0;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/sprite_window.sv
// Box hit test and sprite-local address for one sprite placed at a signed origin.
// Off-screen origins clip naturally because the test is done in signed arithmetic.
module sprite_window
    import sprite_scheduler_pkg::*;
#(
    parameter int SIZE = SPR_SIZE,
    parameter int LW   = $clog2(SIZE),
    parameter int AW   = 2 * LW
) (
    input  logic signed [13:0] origin_col,
    input  logic signed [13:0] origin_row,
    input  logic        [10:0] col,
    input  logic        [10:0] row,
    output logic               hit,
    output logic [AW-1:0]      addr
);

    localparam logic signed [14:0] SIZE_S = 15'(SIZE);

    logic signed [14:0] dc;
    logic signed [14:0] dr;

    assign dc = $signed({4'b0000, col}) - $signed({origin_col[13], origin_col});
    assign dr = $signed({4'b0000, row}) - $signed({origin_row[13], origin_row});

    assign hit  = !dc[14] && (dc < SIZE_S) && !dr[14] && (dr < SIZE_S);
    assign addr = {dr[LW-1:0], dc[LW-1:0]};

endmodule

// File: rtl/sprite_scheduler.sv
// Per-pixel sprite/background sequencer: frame-latched positions, ROM addressing,
// and hero > monster > background priority with a fixed 3-cycle latency.
module sprite_scheduler
    import sprite_scheduler_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        video_on,
    input  logic [10:0] pixel_row,
    input  logic [10:0] pixel_column,
    input  logic [1:0]  world_code,
    input  logic [11:0] LocX,
    input  logic [11:0] LocY,
    input  logic [11:0] LocX_mon,
    input  logic [11:0] LocY_mon,
    input  logic [2:0]  Botinfo,
    output logic [13:0] hero_addr,
    output logic [13:0] mon_addr,
    output logic [15:0] bg_addr,
    input  logic [11:0] hero_front,
    input  logic [11:0] hero_back,
    input  logic [11:0] hero_left,
    input  logic [11:0] hero_right,
    input  logic [11:0] mon_dout,
    input  logic [11:0] dirt_dout,
    input  logic [11:0] wall_dout,
    input  logic [11:0] grass_dout,
    output logic [11:0] pixel_out,
    output logic        pixel_valid
);

    localparam logic signed [13:0] HERO_COL0_S = 14'(HERO_COL0);
    localparam logic signed [13:0] HERO_ROW0_S = 14'(HERO_ROW0);

    logic [0:0]  state;
    logic        frame_start;
    logic        run;
    logic [11:0] lat_x, lat_y, lat_mx, lat_my;
    logic [2:0]  lat_bot;
    logic [11:0] eff_x, eff_y, eff_mx, eff_my;
    logic [2:0]  eff_bot;
    logic signed [12:0] dx, dy;
    logic signed [13:0] mc0, mr0;
    logic        hero_hit, mon_hit;
    logic [13:0] hero_local, mon_local;
    logic [15:0] bg_next;
    side_t       s1, s2;
    logic [11:0] hero_data, bg_data, pix_next;

    assign frame_start = (pixel_row == 11'd0) && (pixel_column == 11'd0);
    assign run         = (state == ACTIVE) || frame_start;

    // The frame-start pixel itself must already see the positions captured with it.
    assign eff_x   = frame_start ? LocX     : lat_x;
    assign eff_y   = frame_start ? LocY     : lat_y;
    assign eff_mx  = frame_start ? LocX_mon : lat_mx;
    assign eff_my  = frame_start ? LocY_mon : lat_my;
    assign eff_bot = frame_start ? Botinfo  : lat_bot;

    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= WAIT_FRAME;
        end else if (frame_start) begin
            state <= ACTIVE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lat_x   <= '0;
            lat_y   <= '0;
            lat_mx  <= '0;
            lat_my  <= '0;
            lat_bot <= '0;
        end else if (frame_start) begin
            lat_x   <= LocX;
            lat_y   <= LocY;
            lat_mx  <= LocX_mon;
            lat_my  <= LocY_mon;
            lat_bot <= Botinfo;
        end
    end

    // The 13-bit difference is widened by one bit so the origin cannot wrap on-screen.
    assign dx  = $signed({1'b0, eff_mx}) - $signed({1'b0, eff_x});
    assign dy  = $signed({1'b0, eff_my}) - $signed({1'b0, eff_y});
    assign mc0 = HERO_COL0_S + {dx[12], dx};
    assign mr0 = HERO_ROW0_S + {dy[12], dy};

    sprite_window #(.SIZE(SPR_SIZE)) u_hero_win (
        .origin_col (HERO_COL0_S),
        .origin_row (HERO_ROW0_S),
        .col        (pixel_column),
        .row        (pixel_row),
        .hit        (hero_hit),
        .addr       (hero_local)
    );

    sprite_window #(.SIZE(SPR_SIZE)) u_mon_win (
        .origin_col (mc0),
        .origin_row (mr0),
        .col        (pixel_column),
        .row        (pixel_row),
        .hit        (mon_hit),
        .addr       (mon_local)
    );

    assign bg_next = 16'({pixel_row[10:1], 9'd0} + {9'd0, pixel_column[10:1]});

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hero_addr <= '0;
            mon_addr  <= '0;
            bg_addr   <= '0;
            s1        <= '0;
        end else begin
            s1.run      <= run;
            s1.video_on <= video_on;
            s1.world    <= world_e'(world_code);
            s1.hero_hit <= hero_hit;
            s1.mon_hit  <= mon_hit;
            s1.orient   <= decode_orient(eff_bot);
            if (run) begin
                bg_addr <= bg_next;
                if (hero_hit) hero_addr <= hero_local;
                if (mon_hit)  mon_addr  <= mon_local;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2 <= '0;
        end else begin
            s2 <= s1;
        end
    end

    // NOTE: each combinational output gets a default first so no latch is inferred.
    always_comb begin
        hero_data = hero_front;
        unique case (s2.orient.view)
            VIEW_FRONT: hero_data = hero_front;
            VIEW_BACK:  hero_data = hero_back;
            VIEW_LEFT:  hero_data = hero_left;
            VIEW_RIGHT: hero_data = hero_right;
        endcase
    end

    always_comb begin
        bg_data = dirt_dout;
        if (s2.world == WALL) begin
            bg_data = wall_dout;
        end else if (s2.world == GRASS) begin
            bg_data = grass_dout;
        end
    end

    always_comb begin
        pix_next = bg_data;
        if (!(s2.run && s2.video_on)) begin
            pix_next = '0;
        end else if (s2.hero_hit && s2.orient.valid && hero_data != TRANSPARENT) begin
            pix_next = hero_data;
        end else if (s2.mon_hit && mon_dout != TRANSPARENT) begin
            pix_next = mon_dout;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pixel_out   <= '0;
            pixel_valid <= 1'b0;
        end else begin
            pixel_out   <= pix_next;
            pixel_valid <= s2.run && s2.video_on;
        end
    end

endmodule

// File: tb/tb_sprite_scheduler.sv
// Self-checking bench: synchronous ROM models, a pixel-level reference model with
// a per-cycle compare process, and directed probes with hand-computed literals.
module tb_sprite_scheduler;
    import sprite_scheduler_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        video_on;
    logic [10:0] pixel_row, pixel_column;
    logic [1:0]  world_code;
    logic [11:0] LocX, LocY, LocX_mon, LocY_mon;
    logic [2:0]  Botinfo;
    logic [13:0] hero_addr, mon_addr;
    logic [15:0] bg_addr;
    logic [11:0] hero_front, hero_back, hero_left, hero_right;
    logic [11:0] mon_dout, dirt_dout, wall_dout, grass_dout;
    logic [11:0] pixel_out;
    logic        pixel_valid;

    always #5 clk = ~clk;

    sprite_scheduler dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .video_on     (video_on),
        .pixel_row    (pixel_row),
        .pixel_column (pixel_column),
        .world_code   (world_code),
        .LocX         (LocX),
        .LocY         (LocY),
        .LocX_mon     (LocX_mon),
        .LocY_mon     (LocY_mon),
        .Botinfo      (Botinfo),
        .hero_addr    (hero_addr),
        .mon_addr     (mon_addr),
        .bg_addr      (bg_addr),
        .hero_front   (hero_front),
        .hero_back    (hero_back),
        .hero_left    (hero_left),
        .hero_right   (hero_right),
        .mon_dout     (mon_dout),
        .dirt_dout    (dirt_dout),
        .wall_dout    (wall_dout),
        .grass_dout   (grass_dout),
        .pixel_out    (pixel_out),
        .pixel_valid  (pixel_valid)
    );

    // ROM images: top nibble fixed per ROM (never zero), low byte = base ^ address.
    localparam logic [11:0] B_FRONT = 12'hABC, B_BACK = 12'h5C3, B_LEFT  = 12'h6D4;
    localparam logic [11:0] B_RIGHT = 12'h7E5, B_MON  = 12'h8F6, B_DIRT  = 12'h9A7;
    localparam logic [11:0] B_WALL  = 12'hC18, B_GRASS = 12'hD29;

    bit tr_hero = 1'b0;
    bit tr_mon  = 1'b0;

    function automatic logic [11:0] rom_word(input logic [11:0] base, input logic [15:0] a,
                                             input bit tr);
        if (tr) return 12'h000;
        return {base[11:8], base[7:0] ^ a[7:0]};
    endfunction

    always @(posedge clk) begin
        hero_front <= rom_word(B_FRONT, {2'b00, hero_addr}, tr_hero);
        hero_back  <= rom_word(B_BACK,  {2'b00, hero_addr}, tr_hero);
        hero_left  <= rom_word(B_LEFT,  {2'b00, hero_addr}, tr_hero);
        hero_right <= rom_word(B_RIGHT, {2'b00, hero_addr}, tr_hero);
        mon_dout   <= rom_word(B_MON,   {2'b00, mon_addr},  tr_mon);
        dirt_dout  <= rom_word(B_DIRT,  bg_addr, 1'b0);
        wall_dout  <= rom_word(B_WALL,  bg_addr, 1'b0);
        grass_dout <= rom_word(B_GRASS, bg_addr, 1'b0);
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model state: frame latch and last-drawn sprite addresses.
    int       cyc = 0;
    bit       m_active;
    int       m_lx, m_ly, m_mx, m_my;
    logic [2:0] m_bot;
    int       m_ha, m_ma, m_ba;
    int       exp_ha[int], exp_ma[int], exp_ba[int], exp_pv[int], exp_po[int];

    logic [13:0] snap_ha, snap_ma;
    logic [15:0] snap_ba;
    logic        snap_pv;
    logic [11:0] snap_po;
    logic [13:0] p_ha, p_ma;
    logic [15:0] p_ba;
    logic        p_pv;
    logic [11:0] p_po;

    task automatic model_clear();
        m_active = 1'b0;
        m_lx = 0; m_ly = 0; m_mx = 0; m_my = 0; m_bot = 3'b000;
        m_ha = 0; m_ma = 0; m_ba = 0;
        exp_ha.delete(); exp_ma.delete(); exp_ba.delete();
        exp_pv.delete(); exp_po.delete();
    endtask

    // Present one pixel at the next falling edge and record what it must produce.
    task automatic pix(input int row, input int col, input bit von, input int wc);
        int mc0, mr0, po;
        bit hh, mh, ov;
        logic [11:0] hbase, hd, md, bd;
        @(negedge clk);
        snap_ha = hero_addr; snap_ma = mon_addr; snap_ba = bg_addr;
        snap_pv = pixel_valid; snap_po = pixel_out;
        pixel_row = 11'(row); pixel_column = 11'(col);
        video_on = von; world_code = 2'(wc);
        if (row == 0 && col == 0) begin
            m_lx = int'(LocX); m_ly = int'(LocY);
            m_mx = int'(LocX_mon); m_my = int'(LocY_mon);
            m_bot = Botinfo;
            m_active = 1'b1;
        end
        hh = m_active && col >= HERO_COL0 && col < HERO_COL0 + 128 &&
             row >= HERO_ROW0 && row < HERO_ROW0 + 128;
        mc0 = HERO_COL0 + (m_mx - m_lx);
        mr0 = HERO_ROW0 + (m_my - m_ly);
        mh = m_active && col >= mc0 && col < mc0 + 128 && row >= mr0 && row < mr0 + 128;
        if (hh) m_ha = (row - HERO_ROW0) * 128 + (col - HERO_COL0);
        if (mh) m_ma = (row - mr0) * 128 + (col - mc0);
        if (m_active) m_ba = ((row / 2) * 512 + col / 2) % 65536;
        exp_ha[cyc + 1] = m_ha; exp_ma[cyc + 1] = m_ma; exp_ba[cyc + 1] = m_ba;

        ov = 1'b1; hbase = B_FRONT;
        case (m_bot)
            3'b100:  hbase = B_FRONT;
            3'b000:  hbase = B_BACK;
            3'b110:  hbase = B_LEFT;
            3'b010:  hbase = B_RIGHT;
            default: ov = 1'b0;
        endcase
        hd = rom_word(hbase, 16'(m_ha), tr_hero);
        md = rom_word(B_MON, 16'(m_ma), tr_mon);
        if (wc == 2)      bd = rom_word(B_WALL,  16'(m_ba), 1'b0);
        else if (wc == 3) bd = rom_word(B_GRASS, 16'(m_ba), 1'b0);
        else              bd = rom_word(B_DIRT,  16'(m_ba), 1'b0);
        if (!m_active || !von)          po = 0;
        else if (hh && ov && hd != 0)   po = int'(hd);
        else if (mh && md != 0)         po = int'(md);
        else                            po = int'(bd);
        exp_pv[cyc + 3] = (m_active && von) ? 1 : 0;
        exp_po[cyc + 3] = po;
    endtask

    // One target pixel followed by blanking; snapshots its addresses and its pixel.
    task automatic probe(input int row, input int col, input bit von, input int wc);
        pix(row, col, von, wc);
        pix(800, 1000, 1'b0, 0);
        p_ha = snap_ha; p_ma = snap_ma; p_ba = snap_ba;
        pix(800, 1000, 1'b0, 0);
        pix(800, 1000, 1'b0, 0);
        p_pv = snap_pv; p_po = snap_po;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pixel_out"},   32'(pixel_out),   32'd0);
        check({tag, "_pixel_valid"}, 32'(pixel_valid), 32'd0);
        check({tag, "_hero_addr"},   32'(hero_addr),   32'd0);
        check({tag, "_mon_addr"},    32'(mon_addr),    32'd0);
        check({tag, "_bg_addr"},     32'(bg_addr),     32'd0);
    endtask

    initial begin : compare
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (exp_ha.exists(cyc)) begin
                check("model_hero_addr", 32'(hero_addr), exp_ha[cyc]);
                check("model_mon_addr",  32'(mon_addr),  exp_ma[cyc]);
                check("model_bg_addr",   32'(bg_addr),   exp_ba[cyc]);
                exp_ha.delete(cyc); exp_ma.delete(cyc); exp_ba.delete(cyc);
            end
            if (exp_pv.exists(cyc)) begin
                check("model_pixel_valid", 32'(pixel_valid), exp_pv[cyc]);
                check("model_pixel_out",   32'(pixel_out),   exp_po[cyc]);
                exp_pv.delete(cyc); exp_po.delete(cyc);
            end
        end
    end

    initial begin : stimulus
        reset_n = 1'b1;
        video_on = 1'b0; pixel_row = 11'd800; pixel_column = 11'd1000; world_code = 2'd0;
        LocX = '0; LocY = '0; LocX_mon = '0; LocY_mon = '0; Botinfo = 3'b000;
        model_clear();
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_all_zero("reset");
        @(negedge clk);
        #1 reset_n = 1'b1;

        // Nothing is drawn before the first frame start.
        probe(320, 448, 1'b1, 0);
        check("preframe_valid", 32'(p_pv), 32'd0);
        check("preframe_haddr", 32'(p_ha), 32'd0);

        // Hero box, monster parked on top of the hero.
        LocX = 12'd2048; LocY = 12'd2048; LocX_mon = 12'd2048; LocY_mon = 12'd2048;
        Botinfo = 3'b100;
        probe(0, 0, 1'b1, 0);
        check("first_valid", 32'(p_pv), 32'd1);
        check("first_pixel", 32'(p_po), 32'h9A7);
        probe(320, 448, 1'b1, 0);
        check("hero_tl_addr",  32'(p_ha), 32'd0);
        check("hero_tl_pixel", 32'(p_po), 32'hABC);
        probe(447, 575, 1'b1, 0);
        check("hero_br_addr",  32'(p_ha), 32'd16383);
        check("hero_br_pixel", 32'(p_po), 32'hA43);
        probe(320, 576, 1'b1, 3);
        check("hero_right_bg_addr",  32'(p_ba), 32'd16672);
        check("hero_right_bg_pixel", 32'(p_po), 32'hD09);

        // Monster offset and frame latch.
        LocX_mon = 12'd2148; LocY_mon = 12'd1998;
        probe(0, 0, 1'b0, 0);
        probe(270, 548, 1'b1, 0);
        check("mon_origin_addr",  32'(p_ma), 32'd0);
        check("mon_origin_pixel", 32'(p_po), 32'h8F6);
        probe(271, 549, 1'b1, 0);
        check("mon_addr_129", 32'(p_ma), 32'd129);
        LocX = 12'd2064;
        probe(270, 548, 1'b1, 0);
        check("latch_held_addr", 32'(p_ma), 32'd0);
        probe(0, 0, 1'b0, 0);
        probe(270, 532, 1'b1, 0);
        check("latch_moved_addr", 32'(p_ma), 32'd0);

        // Overlap, transparency and blanking.
        LocX = 12'd2048; LocY = 12'd2048; LocX_mon = 12'd2058; LocY_mon = 12'd2058;
        probe(0, 0, 1'b0, 0);
        probe(340, 470, 1'b1, 0);
        check("overlap_haddr", 32'(p_ha), 32'd2582);
        check("overlap_maddr", 32'(p_ma), 32'd1292);
        check("overlap_hero",  32'(p_po), 32'hAAA);
        tr_hero = 1'b1;
        probe(340, 470, 1'b1, 0);
        check("hero_transp_mon", 32'(p_po), 32'h8FA);
        tr_mon = 1'b1;
        probe(340, 470, 1'b1, 2);
        check("both_transp_wall_addr", 32'(p_ba), 32'd21739);
        check("both_transp_wall", 32'(p_po), 32'hCF3);
        probe(340, 470, 1'b0, 2);
        check("blank_valid", 32'(p_pv), 32'd0);
        check("blank_pixel", 32'(p_po), 32'd0);
        tr_hero = 1'b0; tr_mon = 1'b0;

        // Orientation decode.
        Botinfo = 3'b001;
        probe(0, 0, 1'b0, 0);
        probe(340, 470, 1'b1, 0);
        check("bad_orient_mon", 32'(p_po), 32'h8FA);
        Botinfo = 3'b110;
        probe(0, 0, 1'b0, 0);
        probe(340, 470, 1'b1, 0);
        check("left_orient", 32'(p_po), 32'h6C2);

        // Left-edge clipping.
        Botinfo = 3'b100; LocX_mon = 12'd1548; LocY_mon = 12'd2048;
        probe(0, 0, 1'b0, 0);
        probe(330, 0, 1'b1, 0);
        check("clip_col0_addr",  32'(p_ma), 32'd1332);
        check("clip_col0_pixel", 32'(p_po), 32'h8C2);
        probe(330, 75, 1'b1, 0);
        check("clip_last_addr", 32'(p_ma), 32'd1407);
        probe(330, 76, 1'b1, 0);
        check("clip_past_hold",  32'(p_ma), 32'd1407);
        check("clip_past_pixel", 32'(p_po), 32'h981);

        // Extreme offsets must not alias onto the screen.
        LocX = 12'd0; LocY = 12'd0; LocX_mon = 12'd4095; LocY_mon = 12'd0;
        probe(0, 0, 1'b0, 0);
        probe(330, 447, 1'b1, 0);
        check("alias_pos_hold",  32'(p_ma), 32'd1407);
        check("alias_pos_pixel", 32'(p_po), 32'h978);
        LocX = 12'd4095; LocX_mon = 12'd0; LocY = 12'd0; LocY_mon = 12'd0; Botinfo = 3'b001;
        probe(0, 0, 1'b0, 0);
        probe(330, 449, 1'b1, 0);
        check("alias_neg_hold",  32'(p_ma), 32'd1407);
        check("alias_neg_pixel", 32'(p_po), 32'h947);

        // Reset in the middle of a visible run.
        Botinfo = 3'b100; LocX = 12'd2048; LocY = 12'd2048; LocX_mon = 12'd2048; LocY_mon = 12'd2048;
        probe(0, 0, 1'b0, 0);
        for (int c = 460; c < 464; c++) pix(330, c, 1'b1, 0);
        #2 reset_n = 1'b0;
        #1 check_all_zero("midreset");
        model_clear();
        @(negedge clk);
        #1 reset_n = 1'b1;
        probe(330, 470, 1'b1, 0);
        check("post_reset_valid", 32'(p_pv), 32'd0);
        check("post_reset_haddr", 32'(p_ha), 32'd0);
        probe(0, 0, 1'b1, 0);
        check("restart_valid", 32'(p_pv), 32'd1);
        check("restart_pixel", 32'(p_po), 32'h9A7);
        probe(330, 470, 1'b1, 0);
        check("restart_haddr", 32'(p_ha), 32'd1302);
        check("restart_hero",  32'(p_po), 32'hAAA);

        repeat (4) pix(800, 1000, 1'b0, 0);
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
